// File: rtl/cell_chk_pkg.sv
// rtl/cell_chk_pkg.sv - shared types and golden tables for the cell response checkers
package cell_chk_pkg;

  localparam int N_IN  = 6;
  localparam int N_VEC = 64;

  // ZN golden tables, bit v = expected ZN for vector {A1,A2,B1,B2,C1,C2} = v
  localparam logic [N_VEC-1:0] TRUTH_OAI222 = 64'h111F_111F_111F_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/cell_resp_checker_if.sv
// rtl/cell_resp_checker_if.sv - controller and cell-side signals of the response checker
interface cell_resp_checker_if
  import cell_chk_pkg::*;
;
  logic             start;
  logic [N_IN-1:0]  cell_in;
  logic             cell_zn;
  logic             busy;
  logic             done;
  logic             pass;
  logic [6:0]       err_count;
  logic             first_fail_valid;
  logic [N_IN-1:0]  first_fail_vec;
  logic [N_VEC-1:0] resp;

  modport master (
    input  start, cell_zn,
    output cell_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec, resp
  );

  modport slave (
    output start, cell_zn,
    input  cell_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec, resp
  );
endinterface

// File: rtl/cell_vec_gen.sv
// rtl/cell_vec_gen.sv - vector and settle counters for the exhaustive sweep
module cell_vec_gen
  import cell_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            settle_en,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            settle_last,
  output logic            vec_last
);

  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(N_VEC - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
      cnt <= '0;
    end else if (clear) begin
      vec <= '0;
      cnt <= '0;
    end else if (advance) begin
      vec <= vec + 1'b1;
      cnt <= '0;
    end else if (settle_en && !settle_last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign settle_last = (cnt == CNT_LAST);
  assign vec_last    = (vec == VEC_LAST);

endmodule

// File: rtl/cell_resp_checker.sv
// rtl/cell_resp_checker.sv - sweeps all 64 vectors into a 6-in cell and checks ZN against a golden table
module cell_resp_checker
  import cell_chk_pkg::*;
#(
  parameter logic [N_VEC-1:0] TRUTH  = TRUTH_OAI222,
  parameter int               SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  cell_resp_checker_if.master bus
);

  state_t           state;
  logic [N_IN-1:0]  vec;
  logic             settle_last;
  logic             vec_last;
  logic             start_ok;
  logic             mismatch;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [6:0]       err_q;
  logic             ff_valid_q;
  logic [N_IN-1:0]  ff_vec_q;
  logic [N_VEC-1:0] resp_q;

  assign start_ok = bus.start && (state == S_IDLE || state == S_DONE);
  // X on the cell output must count as a failure, hence the case-inequality
  assign mismatch = (bus.cell_zn !== TRUTH[vec]);

  cell_vec_gen #(.SETTLE(SETTLE)) u_vec_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_ok),
    .settle_en   (state == S_SETTLE),
    .advance     (state == S_CHECK && !vec_last),
    .vec         (vec),
    .settle_last (settle_last),
    .vec_last    (vec_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      resp_q     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state      <= S_SETTLE;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            resp_q     <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_last) state <= S_CHECK;
        end
        S_CHECK: begin
          resp_q[vec] <= bus.cell_zn;
          if (mismatch) begin
            err_q <= err_q + 7'd1;
            if (!ff_valid_q) begin
              ff_valid_q <= 1'b1;
              ff_vec_q   <= vec;
            end
          end
          if (vec_last) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == 7'd0) && !mismatch;
          end else begin
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cell_in          = vec;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign bus.resp             = resp_q;

endmodule

// File: tb/tb_cell_resp_checker.sv
// tb/tb_cell_resp_checker.sv - directed bench for cell_resp_checker with behavioural OAI222 cells
module tb_cell_resp_checker;
  import cell_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  always #5 clk = ~clk;

  cell_resp_checker_if bus1 ();
  cell_resp_checker_if bus2 ();

  cell_resp_checker #(.TRUTH(64'h111F_111F_111F_FFFF), .SETTLE(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  cell_resp_checker #(.TRUTH(64'h111F_111F_111F_FFFF), .SETTLE(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic oai(input logic [5:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // mode 0: ideal cell, 1: ZN stuck 0, 2: ZN stuck 1
  always_comb begin
    bus1.cell_zn = oai(bus1.cell_in);
    if (mode == 1) bus1.cell_zn = 1'b0;
    else if (mode == 2) bus1.cell_zn = 1'b1;
  end

  always_comb bus2.cell_zn = oai(bus2.cell_in) ^ (bus2.cell_in == 6'd63);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run1(input bit repulse, output int n);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    check_val("busy_after_start", 64'(bus1.busy), 64'd1);
    check_val("done_cleared", 64'(bus1.done), 64'd0);
    check_val("err_cleared", 64'(bus1.err_count), 64'd0);
    check_val("ffv_cleared", 64'(bus1.first_fail_valid), 64'd0);
    check_val("resp_cleared", bus1.resp, 64'd0);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1 n++;
      if (bus1.done) break;
      bus1.start = repulse && (n == 10 || n == 100 || n == 191);
    end
    bus1.start = 1'b0;
    check_val("done_seen", 64'(bus1.done), 64'd1);
  endtask

  initial begin
    bus1.start = 1'b0;
    bus2.start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(bus1.busy), 64'd0);
    check_val("rst_done", 64'(bus1.done), 64'd0);
    check_val("rst_pass", 64'(bus1.pass), 64'd0);
    check_val("rst_err", 64'(bus1.err_count), 64'd0);
    check_val("rst_ffv", 64'(bus1.first_fail_valid), 64'd0);
    check_val("rst_ffvec", 64'(bus1.first_fail_vec), 64'd0);
    check_val("rst_resp", bus1.resp, 64'd0);
    check_val("rst_cell_in", 64'(bus1.cell_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    run1(1'b0, cyc);
    check_val("ideal_cycles", 64'(cyc), 64'd192);
    check_val("ideal_pass", 64'(bus1.pass), 64'd1);
    check_val("ideal_err", 64'(bus1.err_count), 64'd0);
    check_val("ideal_ffv", 64'(bus1.first_fail_valid), 64'd0);
    check_val("ideal_resp", bus1.resp, 64'h111F_111F_111F_FFFF);
    check_val("ideal_busy", 64'(bus1.busy), 64'd0);

    mode = 1;
    run1(1'b0, cyc);
    check_val("z0_err", 64'(bus1.err_count), 64'd37);
    check_val("z0_ffv", 64'(bus1.first_fail_valid), 64'd1);
    check_val("z0_ffvec", 64'(bus1.first_fail_vec), 64'd0);
    check_val("z0_pass", 64'(bus1.pass), 64'd0);
    check_val("z0_resp", bus1.resp, 64'd0);
    check_val("z0_cell_in_held", 64'(bus1.cell_in), 64'd63);

    mode = 2;
    run1(1'b0, cyc);
    check_val("z1_err", 64'(bus1.err_count), 64'd27);
    check_val("z1_ffvec", 64'(bus1.first_fail_vec), 64'd21);
    check_val("z1_resp", bus1.resp, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("z1_pass", 64'(bus1.pass), 64'd0);

    mode = 0;
    run1(1'b0, cyc);
    check_val("restart_cycles", 64'(cyc), 64'd192);
    check_val("restart_pass", 64'(bus1.pass), 64'd1);
    check_val("restart_err", 64'(bus1.err_count), 64'd0);

    run1(1'b1, cyc);
    check_val("repulse_cycles", 64'(cyc), 64'd192);
    check_val("repulse_pass", 64'(bus1.pass), 64'd1);
    check_val("repulse_resp", bus1.resp, 64'h111F_111F_111F_FFFF);

    mode = 1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_val("mid_err", 64'(bus1.err_count), 64'd16);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(bus1.busy), 64'd0);
    check_val("arst_err", 64'(bus1.err_count), 64'd0);
    check_val("arst_ffv", 64'(bus1.first_fail_valid), 64'd0);
    check_val("arst_cell_in", 64'(bus1.cell_in), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    check_val("post_rst_done", 64'(bus1.done), 64'd0);
    check_val("post_rst_busy", 64'(bus1.busy), 64'd0);

    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
      if (bus2.done) break;
    end
    check_val("s1_done", 64'(bus2.done), 64'd1);
    check_val("s1_cycles", 64'(cyc), 64'd128);
    check_val("s1_err", 64'(bus2.err_count), 64'd1);
    check_val("s1_ffvec", 64'(bus2.first_fail_vec), 64'd63);
    check_val("s1_pass", 64'(bus2.pass), 64'd0);
    check_val("s1_resp", bus2.resp, 64'h911F_111F_111F_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
